// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Summary  : Round-robin two-port front end for a single shared ALU, with one
//            operation in flight and a fixed ALU latency.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 1,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_negative,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_negative,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,

    output logic              busy
);

    localparam logic [3:0] c_LAT = 4'(ALU_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ptr;
    logic       r_id;
    logic [3:0] r_cnt;

    logic       w_grant;
    logic       w_accept;
    logic       w_done;
    logic       w_take;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = r_ptr;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = (r_state == ST_IDLE) && req0_valid && !w_grant;
    assign req1_ready = (r_state == ST_IDLE) && req1_valid &&  w_grant;
    assign w_accept   = req0_ready || req1_ready;
    assign w_done     = (r_state == ST_EXEC) && (r_cnt == c_LAT);
    assign w_take     = (r_state == ST_RESP) && (r_id ? rsp1_ready : rsp0_ready);

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_done)   w_state_nxt = ST_RESP;
            ST_RESP: if (w_take)   w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= 1'b0;
            r_id          <= 1'b0;
            r_cnt         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_negative <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_negative <= 1'b0;
        end else begin
            // ALU operands change only here, so they stay put through EXEC/RESP/IDLE.
            if (w_accept) begin
                r_id   <= w_grant;
                r_ptr  <= ~w_grant;
                r_cnt  <= '0;
                alu_a  <= w_grant ? req1_a  : req0_a;
                alu_b  <= w_grant ? req1_b  : req0_b;
                alu_op <= w_grant ? req1_op : req0_op;
            end

            if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_done) begin
                if (r_id) begin
                    rsp1_valid    <= 1'b1;
                    rsp1_result   <= alu_result;
                    rsp1_negative <= alu_negative;
                end else begin
                    rsp0_valid    <= 1'b1;
                    rsp0_result   <= alu_result;
                    rsp0_negative <= alu_negative;
                end
            end

            if (w_take) begin
                if (r_id) begin
                    rsp1_valid <= 1'b0;
                end else begin
                    rsp0_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Summary  : Self-checking bench: directed cases plus randomized traffic scored
//            against a transaction-level model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_negative, rsp1_negative;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_op, alu_negative, busy;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bench ALU: op 0 = add, 1 = sub; Negative is the result sign bit.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
        logic [31:0] r;
        r = op ? (a - b) : (a + b);
        return {r[31], r};
    endfunction

    always @(posedge clk) {alu_negative, alu_result} <= alu_ref(alu_a, alu_b, alu_op);

    alu_arbiter #(.DATA_W(32), .OP_W(1), .ALU_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_negative(rsp0_negative),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_negative(rsp1_negative),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_negative(alu_negative),
        .busy(busy)
    );

    // Latency-sweep instances (0 and 3) share one port-0 stimulus.
    logic        sw_valid, sw_rsp_ready, sw_op;
    logic [31:0] sw_a, sw_b;
    logic        sw_ready [2];
    logic        sw_rvalid [2];
    logic        sw_neg [2];
    logic        sw_busy [2];
    logic [31:0] sw_res [2];

    for (genvar k = 0; k < 2; k++) begin : g_sweep
        localparam int LAT = (k == 0) ? 0 : 3;
        logic [31:0] s_alu_a, s_alu_b, s_res, s_r1_res;
        logic        s_alu_op, s_neg, s_r1_ready, s_r1_valid, s_r1_neg;
        logic [32:0] s_f;
        assign s_f = alu_ref(s_alu_a, s_alu_b, s_alu_op);
        if (LAT == 0) begin : g_comb
            assign {s_neg, s_res} = s_f;
        end else begin : g_pipe
            logic [32:0] pipe [LAT];
            always @(posedge clk) begin
                pipe[0] <= s_f;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign {s_neg, s_res} = pipe[LAT-1];
        end
        alu_arbiter #(.DATA_W(32), .OP_W(1), .ALU_LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(sw_valid), .req0_ready(sw_ready[k]),
            .req0_a(sw_a), .req0_b(sw_b), .req0_op(sw_op),
            .req1_valid(1'b0), .req1_ready(s_r1_ready),
            .req1_a(32'd0), .req1_b(32'd0), .req1_op(1'b0),
            .rsp0_valid(sw_rvalid[k]), .rsp0_ready(sw_rsp_ready),
            .rsp0_result(sw_res[k]), .rsp0_negative(sw_neg[k]),
            .rsp1_valid(s_r1_valid), .rsp1_ready(1'b1),
            .rsp1_result(s_r1_res), .rsp1_negative(s_r1_neg),
            .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
            .alu_result(s_res), .alu_negative(s_neg),
            .busy(sw_busy[k])
        );
    end

    // ---------------- Transaction-level reference model ----------------
    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    bit          m_busy = 0;
    bit          m_id, m_seen, m_fav;
    int unsigned m_acc_cyc, m_d;
    logic [31:0] m_res_exp;
    logic        m_neg_exp;
    logic [31:0] m_alu_a = '0, m_alu_b = '0;
    logic        m_alu_op = 1'b0;
    logic [31:0] m_res [2] = '{32'd0, 32'd0};
    logic        m_neg [2] = '{1'b0, 1'b0};
    logic        m_v, m_vo, m_exp0, m_exp1;
    bit          grant_log [$];

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_fav = 0;
            m_alu_a = '0; m_alu_b = '0; m_alu_op = 1'b0;
            m_res[0] = '0; m_res[1] = '0; m_neg[0] = 1'b0; m_neg[1] = 1'b0;
        end else begin
            chk("m_busy", busy, m_busy);
            chk("m_alu_a", alu_a, m_alu_a);
            chk("m_alu_b", alu_b, m_alu_b);
            chk("m_alu_op", alu_op, m_alu_op);
            if (m_busy) begin
                chk("m_ready0_busy", req0_ready, 0);
                chk("m_ready1_busy", req1_ready, 0);
                m_v  = m_id ? rsp1_valid : rsp0_valid;
                m_vo = m_id ? rsp0_valid : rsp1_valid;
                chk("m_rsp_other", m_vo, 0);
                if (!m_seen) begin
                    m_d = cyc_n - m_acc_cyc;
                    chk("m_rsp_lat", m_v, (m_d == L + 2));
                    if (m_v || m_d >= L + 2) m_seen = 1;
                end
                if (m_v) begin
                    m_res[m_id] = m_res_exp;
                    m_neg[m_id] = m_neg_exp;
                    if (m_id ? rsp1_ready : rsp0_ready) m_busy = 0;
                end
            end else begin
                chk("m_rsp0_idle", rsp0_valid, 0);
                chk("m_rsp1_idle", rsp1_valid, 0);
                if (req0_valid || req1_valid) begin
                    m_exp0 = req0_valid && (!req1_valid || m_fav == 0);
                    m_exp1 = req1_valid && !m_exp0;
                    chk("m_ready0", req0_ready, m_exp0);
                    chk("m_ready1", req1_ready, m_exp1);
                    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                        m_id      = !(req0_valid && req0_ready);
                        m_alu_a   = m_id ? req1_a  : req0_a;
                        m_alu_b   = m_id ? req1_b  : req0_b;
                        m_alu_op  = m_id ? req1_op : req0_op;
                        {m_neg_exp, m_res_exp} = alu_ref(m_alu_a, m_alu_b, m_alu_op);
                        m_busy    = 1;
                        m_seen    = 0;
                        m_acc_cyc = cyc_n;
                        m_fav     = !m_id;
                        grant_log.push_back(m_id);
                    end
                end
            end
            chk("m_rsp0_res", rsp0_result, m_res[0]);
            chk("m_rsp0_neg", rsp0_negative, m_neg[0]);
            chk("m_rsp1_res", rsp1_result, m_res[1]);
            chk("m_rsp1_neg", rsp1_negative, m_neg[1]);
        end
    end

    // ---------------- Stimulus helpers ----------------
    function automatic logic [31:0] log_bits();
        logic [31:0] b;
        b = '0;
        foreach (grant_log[i]) b = {b[30:0], grant_log[i]};
        return b;
    endfunction

    task automatic new_pay0();
        req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom_range(0, 1));
    endtask

    task automatic new_pay1();
        req1_a = $urandom; req1_b = $urandom; req1_op = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic wait_idle(input int maxc);
        bit done;
        done = 0;
        for (int c = 0; c < maxc && !done; c++) begin
            @(negedge clk);
            if (!busy && !rsp0_valid && !rsp1_valid) done = 1;
        end
        if (!done) chk("idle_timeout", busy, 0);
    endtask

    task automatic run_ops(input bit v0, input bit v1, input int n);
        int  got;
        bit  a0, a1;
        got = 0;
        @(posedge clk); #1;
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = v0; req1_valid = v1;
        new_pay0(); new_pay1();
        for (int c = 0; c < n * 10 + 20 && got < n; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) begin got++; new_pay0(); end
            if (a1) begin got++; new_pay1(); end
        end
        req0_valid = 0; req1_valid = 0;
        chk("ops_count", got, n);
        wait_idle(20);
    endtask

    // ---------------- Directed + random sequence ----------------
    initial begin
        bit          seen, got0, got1, a0, a1;
        int          first [2];
        int          n0, n1;
        logic [31:0] cap_res;
        logic        cap_neg;

        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = 0; req1_a = '0; req1_b = '0; req1_op = 0;
        sw_valid = 0; sw_rsp_ready = 0; sw_a = '0; sw_b = '0; sw_op = 0;

        // Reset values
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_neg", rsp1_negative, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0;

        // Single request: 14 - 15
        req0_valid = 1; req0_a = 32'd14; req0_b = 32'd15; req0_op = 1; rsp0_ready = 1;
        @(negedge clk);
        chk("single_ready", req0_ready, 1);
        chk("single_busy_idle", busy, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("single_busy_e0", busy, 1);
        chk("single_valid_e0", rsp0_valid, 0);
        @(negedge clk);
        chk("single_valid_e1", rsp0_valid, 0);
        @(negedge clk);
        chk("single_valid_e2", rsp0_valid, 1);
        chk("single_result", rsp0_result, 32'hFFFF_FFFF);
        chk("single_negative", rsp0_negative, 1);
        chk("single_busy_resp", busy, 1);
        @(negedge clk);
        chk("single_valid_done", rsp0_valid, 0);
        chk("single_busy_done", busy, 0);

        // Latency sweep: ALU_LATENCY 0 and 3
        @(posedge clk); #1;
        sw_valid = 1; sw_a = 32'd14; sw_b = 32'd15; sw_op = 1; sw_rsp_ready = 1;
        @(negedge clk);
        chk("sw_ready_l0", sw_ready[0], 1);
        chk("sw_ready_l3", sw_ready[1], 1);
        @(posedge clk); #1;
        sw_valid = 0;
        first[0] = -1; first[1] = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (first[k] < 0 && sw_rvalid[k]) begin
                    first[k] = n;
                    chk("sw_result", sw_res[k], 32'hFFFF_FFFF);
                    chk("sw_negative", sw_neg[k], 1);
                end
            end
        end
        chk("sw_lat_l0", first[0], 1);
        chk("sw_lat_l3", first[1], 4);
        chk("sw_busy_l3", sw_busy[1], 0);

        // Simultaneous requests at reset exit
        @(posedge clk); #1;
        rst = 1;
        req0_valid = 1; req0_a = 32'd14; req0_b = 32'd15; req0_op = 0;
        req1_valid = 1; req1_a = 32'd20; req1_b = 32'd5;  req1_op = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        grant_log.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        seen = 0; got0 = 0; got1 = 0;
        for (int c = 0; c < 30 && !got1; c++) begin
            @(negedge clk);
            if (!got0 && rsp1_valid) seen = 1;
            if (rsp0_valid && !got0) begin
                chk("sim_res0", rsp0_result, 32'd29);
                chk("sim_neg0", rsp0_negative, 0);
                got0 = 1;
            end
            if (rsp1_valid && !got1) begin
                chk("sim_res1", rsp1_result, 32'd15);
                chk("sim_neg1", rsp1_negative, 0);
                got1 = 1;
            end
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0;
        chk("sim_rsp1_early", seen, 0);
        chk("sim_got0", got0, 1);
        chk("sim_got1", got1, 1);
        chk("sim_order", log_bits(), 32'b01);
        wait_idle(20);

        // Fairness: both valid for 6 operations
        do_reset();
        grant_log.delete();
        run_ops(1, 1, 6);
        chk("fair_alt_n", grant_log.size(), 6);
        chk("fair_alt", log_bits(), 32'b010101);

        // Fairness: req1 alone x3, then both
        do_reset();
        grant_log.delete();
        run_ops(0, 1, 3);
        run_ops(1, 1, 1);
        chk("fair_solo_n", grant_log.size(), 4);
        chk("fair_solo", log_bits(), 32'b1110);

        // Backpressure on rsp0 with req1 waiting
        grant_log.delete();
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 1;
        req0_valid = 1; new_pay0();
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (req0_ready) seen = 1;
            @(posedge clk); #1;
        end
        req0_valid = 0;
        chk("bp_accept", seen, 1);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rsp0_valid) seen = 1;
        end
        chk("bp_rsp_seen", seen, 1);
        {cap_neg, cap_res} = alu_ref(req0_a, req0_b, req0_op);
        chk("bp_result", rsp0_result, cap_res);
        @(posedge clk); #1;
        req1_valid = 1; new_pay1();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp0_valid, 1);
            chk("bp_hold_result", rsp0_result, cap_res);
            chk("bp_hold_neg", rsp0_negative, cap_neg);
            chk("bp_req1_blocked", req1_ready, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1;
        @(negedge clk);
        chk("bp_hs_valid", rsp0_valid, 1);
        @(negedge clk);
        chk("bp_req1_ready", req1_ready, 1);
        chk("bp_idle", busy, 0);
        @(posedge clk); #1;
        req1_valid = 0;
        @(negedge clk);
        chk("bp_req1_busy", busy, 1);
        chk("bp_grants", log_bits(), 32'b01);
        wait_idle(20);

        // Reset during EXEC
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'h1234; req0_b = 32'd5; req0_op = 1; rsp0_ready = 1;
        @(negedge clk);
        chk("rm_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0; rst = 1;
        @(negedge clk);
        chk("rm_busy_exec", busy, 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rm_busy", busy, 0);
        chk("rm_rsp0_valid", rsp0_valid, 0);
        chk("rm_rsp1_valid", rsp1_valid, 0);
        chk("rm_alu_a", alu_a, 0);
        chk("rm_alu_b", alu_b, 0);
        chk("rm_alu_op", alu_op, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen = 1;
        end
        chk("rm_no_rsp", seen, 0);

        // Randomized traffic against the model
        n0 = 0; n1 = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) begin req0_valid = 0; n0++; end
            if (a1) begin req1_valid = 0; n1++; end
            if (!req0_valid && $urandom_range(0, 2) == 0) begin req0_valid = 1; new_pay0(); end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin req1_valid = 1; new_pay1(); end
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        wait_idle(30);
        chk("rand_both_served", (n0 > 5) && (n1 > 5), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
